pwm_gen: RTL and testbench



---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_channel.sv | 38 +++
 rtl/pwm_gen.sv | 72 +++++++
 tb/tb_pwm_gen.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared constants and phase helper for the phase-shifted PWM generator
package pwm_pkg;

    localparam int NUM_CH = 8;

    // Wrapped channel phase: (cnt - idx*step) mod period, using a single
    // conditional add of period when the subtraction would underflow.
    // Valid for any period (power of two or not) as long as cnt < period
    // and idx*step < period.
    function automatic logic [31:0] phase_of(
        input logic [31:0] cnt,
        input int          idx,
        input int          step,
        input int          period
    );
        logic [31:0] off;
        logic [31:0] per;
        off = idx * step;
        per = period;
        if (cnt >= off) begin
            phase_of = cnt - off;
        end else begin
            phase_of = cnt + per - off;
        end
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// rtl/pwm_channel.sv - one PWM channel: phase offset, duty compare and output register
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int IDX    = 0,
    parameter int STEP   = 32,
    parameter int PERIOD = 256,
    parameter int DUTY   = 128,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] cnt,
    output logic             pwm_o
);

    // DUTY may equal 2^CNT_W, so the compare is done at 32 bits.
    localparam logic [31:0] DUTY_U = DUTY;

    logic [31:0] w_ph;
    logic        w_active;
    logic        r_pwm;

    assign w_ph     = phase_of({{(32-CNT_W){1'b0}}, cnt}, IDX, STEP, PERIOD);
    assign w_active = (w_ph < DUTY_U);

    // Output register: follows the phase compare every clock, one cycle behind cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_active;
        end
    end

    assign pwm_o = r_pwm;

endmodule

// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - free-running eight-channel phase-shifted PWM pattern source
module pwm_gen
    import pwm_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int PERIOD   = 256,
    parameter int DUTY     = 128,
    parameter int PRESCALE = 1
) (
    input  logic              clk,
    input  logic              rst,
    output logic [NUM_CH-1:0] pwm
);

    localparam int STEP  = PERIOD / NUM_CH;
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    // Reject illegal parameter combinations at elaboration.
    if (CNT_W < 1 || CNT_W > 31 || PERIOD < 8 || PERIOD > (1 << CNT_W) ||
        DUTY < 0 || DUTY > PERIOD || PRESCALE < 1) begin : g_param_err
        $error("pwm_gen: illegal parameters CNT_W=%0d PERIOD=%0d DUTY=%0d PRESCALE=%0d",
               CNT_W, PERIOD, DUTY, PRESCALE);
    end

    logic [PRE_W-1:0]  r_pre_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_tick;
    logic [NUM_CH-1:0] w_pwm;

    // With PRESCALE=1 the prescaler is a constant zero and tick is always high.
    assign w_tick = (r_pre_cnt == PRE_LAST);

    // Prescaler: counts 0..PRESCALE-1 and wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt <= '0;
        end else if (w_tick) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + 1'b1;
        end
    end

    // Shared period counter: advances on tick, wraps at PERIOD-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        pwm_channel #(
            .IDX   (gi),
            .STEP  (STEP),
            .PERIOD(PERIOD),
            .DUTY  (DUTY),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .cnt  (r_cnt),
            .pwm_o(w_pwm[gi])
        );
    end

    assign pwm = w_pwm;

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen across four parameter sets
module tb_pwm_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pwm_dflt;
    logic [7:0] pwm_d0;
    logic [7:0] pwm_df;
    logic [7:0] pwm_ps;

    int tests = 0;
    int fails = 0;
    int n     = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pwm_gen u_dflt (.clk(clk), .rst(rst), .pwm(pwm_dflt));
    pwm_gen #(.DUTY(0))   u_d0 (.clk(clk), .rst(rst), .pwm(pwm_d0));
    pwm_gen #(.DUTY(256)) u_df (.clk(clk), .rst(rst), .pwm(pwm_df));
    pwm_gen #(.CNT_W(8), .PERIOD(200), .DUTY(50), .PRESCALE(3)) u_ps (.clk(clk), .rst(rst), .pwm(pwm_ps));

    // Clock edges seen with rst low since the last reset edge.
    always @(posedge clk) begin
        if (rst) n <= 0;
        else     n <= n + 1;
    end

    // Reference: after the k-th released edge the outputs show the counter
    // value from before that edge, floor((k-1)/ps) mod per.
    function automatic logic [7:0] model(input int k, input int per, input int duty, input int ps);
        logic [7:0] r;
        int c, step, ph;
        r = 8'h00;
        if (k > 0) begin
            c    = ((k - 1) / ps) % per;
            step = per / 8;
            for (int i = 0; i < 8; i++) begin
                ph   = (((c - i * step) % per) + per) % per;
                r[i] = (ph < duty);
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (n=%0d t=%0t)", name, act, exp, n, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Continuous comparison of every instance against the reference.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dflt", pwm_dflt, model(n, 256, 128, 1));
            check("model_d0",   pwm_d0,   model(n, 256, 0,   1));
            check("model_df",   pwm_df,   model(n, 256, 256, 1));
            check("model_ps",   pwm_ps,   model(n, 200, 50,  3));
        end
    end

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check_int("wait_n_reached", n, target);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        int         k;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int r0, f0, r0b, r1;
        logic [7:0] prev;

        vecs[0] = '{1,   8'b1110_0001, "first_after_reset"};
        vecs[1] = '{33,  8'b1100_0011, "cnt32"};
        vecs[2] = '{129, 8'b0001_1110, "cnt128"};
        vecs[3] = '{161, 8'b0011_1100, "cnt160"};
        vecs[4] = '{256, 8'b1111_0000, "cnt255"};
        vecs[5] = '{257, 8'b1110_0001, "wrap_cnt0"};
        vecs[6] = '{289, 8'b1100_0011, "cnt32_period2"};

        // Reset held for 5 clocks: all outputs low.
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("reset_dflt", pwm_dflt, 8'h00);
            check("reset_ps",   pwm_ps,   8'h00);
            check("reset_df",   pwm_df,   8'h00);
        end
        chk_en = 1'b1;
        rst    = 1'b0;

        // Rotation points for the default configuration.
        foreach (vecs[v]) begin
            wait_n(vecs[v].k);
            check(vecs[v].name, pwm_dflt, vecs[v].exp);
        end

        // Duty boundaries over 512 clocks.
        repeat (512) begin
            @(negedge clk);
            check("duty0_low",     pwm_d0, 8'h00);
            check("dutyfull_high", pwm_df, 8'hFF);
        end

        // Prescaled non-power-of-two period: edge timing of channels 0 and 1.
        do_reset(2);
        r0 = -1; f0 = -1; r0b = -1; r1 = -1;
        prev = 8'h00;
        repeat (700) begin
            @(negedge clk);
            if (pwm_ps[0] && !prev[0]) begin
                if (r0 < 0) r0 = n;
                else if (r0b < 0) r0b = n;
            end
            if (!pwm_ps[0] && prev[0] && f0 < 0) f0 = n;
            if (pwm_ps[1] && !prev[1] && r1 < 0) r1 = n;
            prev = pwm_ps;
        end
        check_int("ps_ch0_first_rise", r0, 1);
        check_int("ps_ch0_high_len",   f0 - r0, 150);
        check_int("ps_ch1_rise_delay", r1 - r0, 75);
        check_int("ps_period",         r0b - r0, 600);

        // Single-clock reset in mid-period at cnt=77.
        do_reset(2);
        wait_n(77);
        rst = 1'b1;
        @(negedge clk);
        check("midreset_dflt", pwm_dflt, 8'h00);
        check("midreset_ps",   pwm_ps,   8'h00);
        rst = 1'b0;
        @(negedge clk);
        check("midreset_restart", pwm_dflt, 8'b1110_0001);
        wait_n(33);
        check("midreset_cnt32", pwm_dflt, 8'b1100_0011);

        // Random reset pulses while the reference tracks every clock.
        repeat (3000) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) < 3);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
